// File: rtl/draw_rect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_rect_pkg
// Purpose  : Shared types for the rectangle pixel generator: the sequencer
//            state enumeration, the mode encodings and a helper that picks
//            the first drawing state for a given mode.
// Ports    : none (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package draw_rect_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TOP    = 3'd1,
        RIGHT  = 3'd2,
        BOTTOM = 3'd3,
        LEFT   = 3'd4,
        FILL   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic MODE_OUTLINE = 1'b0;
    localparam logic MODE_FILL    = 1'b1;

    // First drawing state for a non-degenerate rectangle.
    function automatic state_t first_state(input logic mode);
        state_t s;
        case (mode)
            MODE_OUTLINE: s = TOP;
            MODE_FILL:    s = FILL;
            default:      s = TOP;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : rect_axis_counter
// Purpose  : Loadable up/down coordinate counter with a terminal-count flag.
//            Arithmetic wraps modulo 2^WIDTH.
// Ports    : clk      - clock
//            rst_n    - synchronous active-low reset (value -> 0)
//            load     - load load_val (highest priority)
//            load_val - value to load
//            up       - increment by one
//            down     - decrement by one (ignored when up is set)
//            term     - terminal value to compare against
//            value    - current count
//            tc       - value == term
// Revision : 1.0 - initial release
// ============================================================================
module rect_axis_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] value,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (up) begin
            value <= value + WIDTH'(1);
        end else if (down) begin
            value <= value - WIDTH'(1);
        end
    end

    assign tc = (value == term);

endmodule
`default_nettype wire

// File: rtl/draw_rect_gen.sv
`default_nettype none
// ============================================================================
// Module   : draw_rect_gen
// Purpose  : Streams the pixel coordinates of an axis-aligned rectangle, one
//            per accepted valid/ready beat. Outline mode walks the border
//            clockwise visiting each pixel once; fill mode walks raster order.
// Ports    : _clock   - clock
//            _reset_n - synchronous active-low reset
//            _start   - start request, sampled only in IDLE
//            _mode    - 0 outline, 1 filled (latched at start)
//            s_x, s_y - top-left corner (latched at start)
//            width, height - size in pixels (latched at start)
//            _ready   - downstream accepts the current pixel
//            _out0/_out1 - pixel x / y
//            _valid   - a pixel is presented
//            _busy    - operation in progress (through the DONE cycle)
//            _done    - one-cycle completion pulse
// Revision : 1.0 - initial parametrised release
// ============================================================================
module draw_rect_gen
    import draw_rect_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             _clock,
    input  logic             _reset_n,
    input  logic             _start,
    input  logic             _mode,
    input  logic [WIDTH-1:0] s_x,
    input  logic [WIDTH-1:0] s_y,
    input  logic [WIDTH-1:0] width,
    input  logic [WIDTH-1:0] height,
    input  logic             _ready,
    output logic [WIDTH-1:0] _out0,
    output logic [WIDTH-1:0] _out1,
    output logic             _valid,
    output logic             _busy,
    output logic             _done
);

    state_t           state, state_nxt;

    // Latched geometry: origin, far corner and the size flags that decide
    // which outline segments exist.
    logic [WIDTH-1:0] sx, sy, xe, ye;
    logic             w_gt1, h_gt1, h_gt2;

    logic             beat;
    logic             x_load, x_up, x_down, y_load, y_up, y_down;
    logic [WIDTH-1:0] x_load_val, y_load_val, x_term, y_term;
    logic [WIDTH-1:0] x_val, y_val;
    logic             x_tc, y_tc;

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            state <= IDLE;
            sx    <= '0;
            sy    <= '0;
            xe    <= '0;
            ye    <= '0;
            w_gt1 <= 1'b0;
            h_gt1 <= 1'b0;
            h_gt2 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && _start) begin
                sx    <= s_x;
                sy    <= s_y;
                xe    <= s_x + width - WIDTH'(1);
                ye    <= s_y + height - WIDTH'(1);
                w_gt1 <= (width > WIDTH'(1));
                h_gt1 <= (height > WIDTH'(1));
                h_gt2 <= (height > WIDTH'(2));
            end
        end
    end

    assign _valid = (state == TOP) || (state == RIGHT) || (state == BOTTOM) ||
                    (state == LEFT) || (state == FILL);
    assign _busy  = (state != IDLE);
    assign _done  = (state == DONE);
    assign beat   = _valid && _ready;
    assign _out0  = x_val;
    assign _out1  = y_val;

    // Segment transitions mostly step the counters by one: the corner pixel
    // of each segment is the last pixel of the previous one, so the next
    // segment begins one step further along the new axis.
    always_comb begin
        state_nxt  = state;
        x_load     = 1'b0;
        x_up       = 1'b0;
        x_down     = 1'b0;
        y_load     = 1'b0;
        y_up       = 1'b0;
        y_down     = 1'b0;
        x_load_val = s_x;
        y_load_val = s_y;
        x_term     = xe;
        y_term     = ye;
        case (state)
            IDLE: begin
                if (_start) begin
                    x_load = 1'b1;
                    y_load = 1'b1;
                    if (width == '0 || height == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = first_state(_mode);
                    end
                end
            end
            TOP: begin
                x_term = xe;
                if (beat) begin
                    if (!x_tc) begin
                        x_up = 1'b1;
                    end else if (h_gt1) begin
                        y_up      = 1'b1;
                        state_nxt = RIGHT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RIGHT: begin
                y_term = ye;
                if (beat) begin
                    if (!y_tc) begin
                        y_up = 1'b1;
                    end else if (w_gt1) begin
                        x_down    = 1'b1;
                        state_nxt = BOTTOM;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            BOTTOM: begin
                x_term = sx;
                if (beat) begin
                    if (!x_tc) begin
                        x_down = 1'b1;
                    end else if (h_gt2) begin
                        y_down    = 1'b1;
                        state_nxt = LEFT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            LEFT: begin
                // The top-left corner was already emitted by TOP.
                y_term = sy + WIDTH'(1);
                if (beat) begin
                    if (!y_tc) begin
                        y_down = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            FILL: begin
                x_term = xe;
                y_term = ye;
                if (beat) begin
                    if (!x_tc) begin
                        x_up = 1'b1;
                    end else if (!y_tc) begin
                        x_load     = 1'b1;
                        x_load_val = sx;
                        y_up       = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    rect_axis_counter #(.WIDTH(WIDTH)) u_x_cnt (
        .clk      (_clock),
        .rst_n    (_reset_n),
        .load     (x_load),
        .load_val (x_load_val),
        .up       (x_up),
        .down     (x_down),
        .term     (x_term),
        .value    (x_val),
        .tc       (x_tc)
    );

    rect_axis_counter #(.WIDTH(WIDTH)) u_y_cnt (
        .clk      (_clock),
        .rst_n    (_reset_n),
        .load     (y_load),
        .load_val (y_load_val),
        .up       (y_up),
        .down     (y_down),
        .term     (y_term),
        .value    (y_val),
        .tc       (y_tc)
    );

endmodule
`default_nettype wire
